// File: rtl/rf_arb_pkg.sv
// Shared types and helpers for the register-file write arbiter.
package rf_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Highest register index is the program counter.
  function automatic int pc_idx(input int sel_width);
    return (1 << sel_width) - 1;
  endfunction

  function automatic int next_rr(input int idx, input int num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first valid requester at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    int j;
    logic found;
    logic [IDX_W-1:0] jx;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jx    = '0;
    for (int k = 0; k < N; k++) begin
      j  = (int'(ptr) + k) % N;
      jx = IDX_W'(j);
      if (!found && valid[jx]) begin
        grant[jx] = 1'b1;
        idx       = jx;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port, with atomic lock
// sequences, lock timeout and PC write protection; one registered output stage.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int bit_width = 32,
  parameter int sel_width = 5,
  parameter int num_req   = 3,
  parameter int lock_max  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [num_req-1:0]             req_valid,
  input  logic [num_req-1:0]             req_lock,
  input  logic [num_req*sel_width-1:0]   req_sel,
  input  logic [num_req*bit_width-1:0]   req_data,
  output logic [num_req-1:0]             req_ready,
  output logic                           rf_en,
  output logic [sel_width-1:0]           rf_sel_c,
  output logic [bit_width-1:0]           rf_data_in,
  output logic [$clog2(num_req)-1:0]     grant_id,
  output logic                           locked,
  output logic                           lock_abort,
  output logic                           wr_violation
);

  localparam int IDX_W = $clog2(num_req);
  localparam int CNT_W = $clog2(lock_max);
  localparam logic [sel_width-1:0] PC_SEL   = sel_width'(pc_idx(sel_width));
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(lock_max - 1);

  arb_state_t             state, state_nxt;
  logic [IDX_W-1:0]       rr_ptr, rr_nxt, owner, owner_nxt;
  logic [CNT_W-1:0]       lock_cnt, cnt_nxt;
  logic [num_req-1:0]     pick_grant, owner_oh, xfer_oh;
  logic [IDX_W-1:0]       pick_idx, xfer_idx;
  logic                   xfer, xfer_lock, force_rel, pc_drop;
  logic [sel_width-1:0]   xfer_sel;
  logic [bit_width-1:0]   xfer_data;

  rr_picker #(
    .N     (num_req),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < num_req; i++) owner_oh[i] = (owner == IDX_W'(i));
  end

  // On the last lock cycle only a releasing beat may pass; otherwise the lock is torn down.
  always_comb begin
    req_ready = '0;
    force_rel = 1'b0;
    if (state == IDLE) begin
      req_ready = pick_grant;
    end else if (lock_cnt != CNT_LAST) begin
      req_ready = owner_oh & req_valid;
    end else begin
      req_ready = owner_oh & req_valid & ~req_lock;
      force_rel = ~|req_ready;
    end
  end

  always_comb begin
    xfer_oh   = req_valid & req_ready;
    xfer      = |xfer_oh;
    xfer_idx  = (state == IDLE) ? pick_idx : owner;
    xfer_sel  = '0;
    xfer_data = '0;
    xfer_lock = 1'b0;
    for (int i = 0; i < num_req; i++) begin
      if (xfer_oh[i]) begin
        xfer_sel  = req_sel[i*sel_width +: sel_width];
        xfer_data = req_data[i*bit_width +: bit_width];
        xfer_lock = req_lock[i];
      end
    end
    pc_drop = xfer && (xfer_idx != '0) && (xfer_sel == PC_SEL);
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr_ptr;
    owner_nxt = owner;
    cnt_nxt   = lock_cnt;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (xfer_lock) begin
            state_nxt = LOCKED;
            owner_nxt = xfer_idx;
            cnt_nxt   = '0;
          end else begin
            rr_nxt = IDX_W'(next_rr(int'(xfer_idx), num_req));
          end
        end
      end
      LOCKED: begin
        cnt_nxt = lock_cnt + CNT_W'(1);
        if ((xfer && !xfer_lock) || force_rel) begin
          state_nxt = IDLE;
          rr_nxt    = IDX_W'(next_rr(int'(owner), num_req));
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      owner    <= owner_nxt;
      lock_cnt <= cnt_nxt;
    end
  end

  // Output stage: one cycle after the accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_en        <= 1'b0;
      rf_sel_c     <= '0;
      rf_data_in   <= '0;
      grant_id     <= '0;
      lock_abort   <= 1'b0;
      wr_violation <= 1'b0;
    end else begin
      rf_en        <= xfer && !pc_drop;
      wr_violation <= pc_drop;
      lock_abort   <= force_rel;
      if (xfer) begin
        rf_sel_c   <= xfer_sel;
        rf_data_in <= xfer_data;
        grant_id   <= xfer_idx;
      end
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written lock/reset
// sequences and randomized traffic against a behavioural reference model.
module tb_rf_write_arbiter;

  localparam int BW = 32;
  localparam int SW = 5;
  localparam int N  = 3;
  localparam int LM = 16;
  localparam int IW = 2;
  localparam logic [SW-1:0] PC = 5'd31;
  localparam logic [BW-1:0] D0 = 32'h1111_0000;
  localparam logic [BW-1:0] D1 = 32'h2222_0000;
  localparam logic [BW-1:0] D2 = 32'h3333_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [N-1:0]           req_valid, req_lock, req_ready;
  logic [N-1:0][SW-1:0]   req_sel;
  logic [N-1:0][BW-1:0]   req_data;
  logic                   rf_en, locked, lock_abort, wr_violation;
  logic [SW-1:0]          rf_sel_c;
  logic [BW-1:0]          rf_data_in;
  logic [IW-1:0]          grant_id;

  rf_write_arbiter #(
    .bit_width (BW),
    .sel_width (SW),
    .num_req   (N),
    .lock_max  (LM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_lock     (req_lock),
    .req_sel      (req_sel),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .rf_en        (rf_en),
    .rf_sel_c     (rf_sel_c),
    .rf_data_in   (rf_data_in),
    .grant_id     (grant_id),
    .locked       (locked),
    .lock_abort   (lock_abort),
    .wr_violation (wr_violation)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            m_locked;
  int            m_ptr, m_owner, m_age, m_gid;
  logic          m_en, m_abort, m_viol;
  logic [SW-1:0] m_sel;
  logic [BW-1:0] m_data;

  typedef struct {
    logic [N-1:0]         valid;
    logic [N-1:0]         lock;
    logic [N-1:0][SW-1:0] sel;
    logic [N-1:0][BW-1:0] data;
    logic [N-1:0]         rdy;
    logic                 en;
    logic [SW-1:0]        osel;
    logic [BW-1:0]        odata;
    logic [IW-1:0]        gid;
    logic                 lkd;
    logic                 viol;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [N-1:0] v, input logic [N-1:0] lk,
                              input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                              input logic [SW-1:0] s2, input logic [BW-1:0] d1,
                              input logic [N-1:0] rdy, input logic en,
                              input logic [SW-1:0] os, input logic [BW-1:0] od,
                              input logic [IW-1:0] gid, input logic lkd, input logic viol);
    vec_t t;
    t.valid = v;   t.lock = lk;
    t.sel   = {s2, s1, s0};
    t.data  = {D2, d1, D0};
    t.rdy   = rdy; t.en = en; t.osel = os; t.odata = od;
    t.gid   = gid; t.lkd = lkd; t.viol = viol;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [N-1:0] v, input logic [N-1:0] lk,
                       input logic [N-1:0][SW-1:0] s, input logic [N-1:0][BW-1:0] d);
    rst       = r;
    req_valid = v;
    req_lock  = lk;
    req_sel   = s;
    req_data  = d;
  endtask

  // Who may move a beat this cycle, from the arbitration rules alone.
  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (!m_locked) begin
      for (int off = 0; off < N; off++) begin
        int j;
        j = (m_ptr + off) % N;
        if (req_valid[j]) begin
          r[j] = 1'b1;
          return r;
        end
      end
    end else if (req_valid[m_owner] && !(m_age == LM - 1 && req_lock[m_owner])) begin
      r[m_owner] = 1'b1;
    end
    return r;
  endfunction

  function automatic void model_update();
    logic [N-1:0] r;
    int hit;
    if (rst) begin
      m_locked = 0; m_ptr = 0; m_owner = 0; m_age = 0; m_gid = 0;
      m_en = 0; m_abort = 0; m_viol = 0; m_sel = '0; m_data = '0;
      return;
    end
    r = model_ready();
    hit = -1;
    for (int i = 0; i < N; i++) if (r[i]) hit = i;
    m_en = 0; m_viol = 0; m_abort = 0;
    if (hit >= 0) begin
      m_sel  = req_sel[hit];
      m_data = req_data[hit];
      m_gid  = hit;
      if (hit != 0 && req_sel[hit] == PC) m_viol = 1;
      else m_en = 1;
    end
    if (!m_locked) begin
      if (hit >= 0) begin
        if (req_lock[hit]) begin
          m_locked = 1; m_owner = hit; m_age = 0;
        end else begin
          m_ptr = (hit + 1) % N;
        end
      end
    end else if (hit >= 0 && !req_lock[hit]) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N;
    end else if (m_age == LM - 1) begin
      m_locked = 0; m_ptr = (m_owner + 1) % N; m_abort = 1;
    end else begin
      m_age++;
    end
  endfunction

  task automatic to_post();
    @(posedge clk);
    model_update();
    #1;
  endtask

  logic [N-1:0][SW-1:0] s_def;
  logic [N-1:0][BW-1:0] d_def;

  initial begin
    logic [N-1:0]         rv, rl, quiet;
    logic [N-1:0][SW-1:0] rs;
    logic [N-1:0][BW-1:0] rd;
    logic                 rr;

    s_def = {5'd3, 5'd2, 5'd1};
    d_def = {D2, D1, D0};

    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b000, 1'b0, 5'd0, '0, 2'd0, 1'b0, 1'b0));
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b001, 1'b1, 5'd1, D0, 2'd0, 1'b0, 1'b0));
      tbl.push_back(mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b010, 1'b1, 5'd2, D1, 2'd1, 1'b0, 1'b0));
      tbl.push_back(mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b100, 1'b1, 5'd3, D2, 2'd2, 1'b0, 1'b0));
    end
    tbl.push_back(mk(3'b001, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b001, 1'b1, 5'd1, D0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(3'b111, 3'b010, 5'd1, 5'd4, 5'd3, D1, 3'b010, 1'b1, 5'd4, D1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(3'b111, 3'b010, 5'd1, 5'd5, 5'd3, D1, 3'b010, 1'b1, 5'd5, D1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(3'b111, 3'b010, 5'd1, 5'd6, 5'd3, D1, 3'b010, 1'b1, 5'd6, D1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 5'd1, 5'd7, 5'd3, D1, 3'b010, 1'b1, 5'd7, D1, 2'd1, 1'b0, 1'b0));
    tbl.push_back(mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b100, 1'b1, 5'd3, D2, 2'd2, 1'b0, 1'b0));
    tbl.push_back(mk(3'b010, 3'b000, 5'd1, PC,   5'd3, 32'hDEAD_BEEF, 3'b010, 1'b0, 5'd0, '0, 2'd1, 1'b0, 1'b1));
    tbl.push_back(mk(3'b001, 3'b000, PC,   5'd2, 5'd3, D1, 3'b001, 1'b1, PC,   D0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(3'b000, 3'b000, 5'd1, 5'd2, 5'd3, D1, 3'b000, 1'b0, 5'd0, '0, 2'd0, 1'b0, 1'b0));

    drive(1'b1, '0, '0, s_def, d_def);
    to_post();
    to_post();
    chk("rst.rf_en", rf_en, 0);
    chk("rst.sel", rf_sel_c, 0);
    chk("rst.data", rf_data_in, 0);
    chk("rst.gid", grant_id, 0);
    chk("rst.locked", locked, 0);
    chk("rst.abort", lock_abort, 0);
    chk("rst.viol", wr_violation, 0);

    foreach (tbl[k]) begin
      drive(1'b0, tbl[k].valid, tbl[k].lock, tbl[k].sel, tbl[k].data);
      @(negedge clk);
      chk($sformatf("v%0d.ready", k), req_ready, tbl[k].rdy);
      to_post();
      chk($sformatf("v%0d.rf_en", k), rf_en, tbl[k].en);
      if (tbl[k].en) begin
        chk($sformatf("v%0d.sel", k), rf_sel_c, tbl[k].osel);
        chk($sformatf("v%0d.data", k), rf_data_in, tbl[k].odata);
      end
      chk($sformatf("v%0d.gid", k), grant_id, tbl[k].gid);
      chk($sformatf("v%0d.locked", k), locked, tbl[k].lkd);
      chk($sformatf("v%0d.viol", k), wr_violation, tbl[k].viol);
      chk($sformatf("v%0d.abort", k), lock_abort, 0);
    end

    // Lock timeout: req2 locks then goes silent while req0 waits.
    drive(1'b0, 3'b100, 3'b100, s_def, d_def);
    @(negedge clk);
    chk("to.lock_ready", req_ready, 3'b100);
    to_post();
    chk("to.locked", locked, 1);
    chk("to.gid", grant_id, 2);
    for (int k = 0; k < LM; k++) begin
      drive(1'b0, 3'b001, 3'b000, s_def, d_def);
      @(negedge clk);
      chk("to.stall_ready", req_ready, 3'b000);
      to_post();
      chk("to.locked_hold", locked, (k < LM - 1));
      chk("to.abort", lock_abort, (k == LM - 1));
      chk("to.rf_en", rf_en, 0);
    end
    drive(1'b0, 3'b001, 3'b000, s_def, d_def);
    @(negedge clk);
    chk("to.after_ready", req_ready, 3'b001);
    to_post();
    chk("to.after_en", rf_en, 1);
    chk("to.after_gid", grant_id, 0);
    chk("to.after_abort", lock_abort, 0);

    // Reset while locked with a beat in flight.
    drive(1'b0, 3'b010, 3'b010, s_def, d_def);
    @(negedge clk);
    chk("rl.ready", req_ready, 3'b010);
    to_post();
    chk("rl.locked", locked, 1);
    drive(1'b1, 3'b011, 3'b010, s_def, d_def);
    @(negedge clk);
    chk("rl.ready_in_rst", req_ready, 3'b010);
    to_post();
    chk("rl.rf_en", rf_en, 0);
    chk("rl.locked", locked, 0);
    chk("rl.gid", grant_id, 0);
    drive(1'b0, 3'b111, 3'b000, s_def, d_def);
    @(negedge clk);
    chk("rl.restart_ready", req_ready, 3'b001);
    to_post();
    chk("rl.restart_en", rf_en, 1);
    chk("rl.restart_sel", rf_sel_c, 1);

    // Randomized traffic against the model.
    quiet = '0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0)
        for (int i = 0; i < N; i++) quiet[i] = ($urandom_range(0, 2) == 0);
      rr = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < N; i++) begin
        rv[i] = !quiet[i] && ($urandom_range(0, 3) != 0);
        rl[i] = ($urandom_range(0, 3) == 0);
        rs[i] = ($urandom_range(0, 7) == 0) ? PC : SW'($urandom);
        rd[i] = $urandom;
      end
      drive(rr, rv, rl, rs, rd);
      @(negedge clk);
      chk("rnd.ready", req_ready, model_ready());
      to_post();
      chk("rnd.rf_en", rf_en, m_en);
      if (m_en) begin
        chk("rnd.sel", rf_sel_c, m_sel);
        chk("rnd.data", rf_data_in, m_data);
      end
      chk("rnd.gid", grant_id, m_gid);
      chk("rnd.locked", locked, m_locked);
      chk("rnd.abort", lock_abort, m_abort);
      chk("rnd.viol", wr_violation, m_viol);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
Shares the single write port of register_file (en/sel_c/data_in) between num_req independent writers, e.g. ALU writeback, UART loader and debug/host access. Per-requester valid/ready handshake, round-robin fairness, optional multi-beat lock for atomic register sequences, and a registered output stage driving the register file. The PC register (index 2**sel_width-1) is writable only by requester 0.

Parameters:
bit_width, 32, data width; matches register_file.
sel_width, 5, register index width; matches register_file.
num_req, 3, number of write requesters (2..8).
lock_max, 16, maximum cycles a lock may be held before forced release (>=2).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  num_req  per-requester write request.
req_lock  in  num_req  hold grant after this beat (sampled with the accepted beat).
req_sel  in  num_req*sel_width  packed target indices; requester i in slice i.
req_data  in  num_req*bit_width  packed write data; requester i in slice i.
req_ready  out  num_req  per-requester accept; one-hot or zero.
rf_en  out  1  to register_file en.
rf_sel_c  out  sel_width  to register_file sel_c.
rf_data_in  out  bit_width  to register_file data_in.
grant_id  out  $clog2(num_req)  index of the last accepted requester.
locked  out  1  high while in LOCKED state.
lock_abort  out  1  one-cycle pulse on forced lock release.
wr_violation  out  1  one-cycle pulse when a PC write from requester !=0 is dropped.

Behaviour:
- Reset: rf_en=0, rf_sel_c=0, rf_data_in=0, grant_id=0, locked=0, lock_abort=0, wr_violation=0, state=IDLE, rr_ptr=0, lock_cnt=0. Reset overrides every other event in the same cycle.
- req_ready is combinational from state, rr_ptr and req_valid. It is never asserted to a requester whose valid is low.
- A transfer occurs when req_valid[i] && req_ready[i]. At most one transfer per cycle.
- Write latency: a transfer in cycle N gives rf_en=1 with that sel/data in cycle N+1. The register file is updated at the end of N+1.
- rf_en=0 in any cycle following a cycle with no transfer. rf_sel_c and rf_data_in hold their last values.
- IDLE: grant goes to the first valid requester searching rr_ptr, rr_ptr+1, ... modulo num_req.
  - Transfer with req_lock=0: rr_ptr <= i+1 mod num_req; stay in IDLE.
  - Transfer with req_lock=1: go to LOCKED, owner <= i, lock_cnt <= 0, rr_ptr unchanged.
- LOCKED: only the owner can receive ready; all other requesters are stalled. lock_cnt increments every cycle.
  - Owner transfer with req_lock=0: return to IDLE, rr_ptr <= owner+1.
  - Owner transfer with req_lock=1: stay in LOCKED.
  - lock_cnt == lock_max-1 with no releasing transfer: ready is forced low that cycle, return to IDLE, rr_ptr <= owner+1, lock_abort pulses.
  - Owner dropping valid does not release the lock.
- PC protection: a transfer from requester !=0 with sel == 2**sel_width-1 is still accepted (ready/handshake normal), but rf_en stays 0 in N+1 and wr_violation=1 in N+1.
- grant_id updates in N+1 alongside rf_en, including on dropped writes.
- Reset mid-lock or with a write pending in the output stage: that write is discarded (rf_en=0 after reset), state returns to IDLE, rr_ptr returns to 0.
- Single requester: back-to-back transfers every cycle give rf_en high continuously. Full throughput, no bubbles.

Decomposition:
- Package rf_arb_pkg holds:
  - state enum (IDLE, LOCKED);
  - localparam PC_IDX = 2**sel_width-1 as a function of sel_width;
  - function next_rr(idx, num_req).
- Sub-module rr_picker: combinational rotate-priority encoder. Inputs are valid vector and rr_ptr; outputs are one-hot grant and index. Instantiated once.
- All state in rf_write_arbiter.

Test Plan:
- Reset, then all valid low for 5 cycles -> rf_en=0, req_ready=0, locked=0 throughout.
- Req0, req1, req2 all valid continuously with sel=1/2/3 and data=A/B/C -> grant order 0,1,2,0,1,2; rf_en=1 every cycle from the 2nd cycle; rf_sel_c sequence 1,2,3,1.
- Req1 transfers with lock=1 for 3 beats (sel 4,5,6), then lock=0 on the 4th beat (sel 7); req0 and req2 held valid -> only req1 ready for 4 beats; next grant goes to req2.
- Req2 locks, then drops valid; lock_max=16 -> after 16 cycles in LOCKED, lock_abort pulses once, locked=0, req0 is granted next cycle.
- Req1 writes sel=31, data=0xDEADBEEF -> handshake completes, rf_en=0 and wr_violation=1 the next cycle. Req0 writes sel=31 -> rf_en=1, rf_sel_c=31.
- Assert rst while LOCKED with a transfer in the same cycle -> next cycle rf_en=0, locked=0, and the grant restarts from req0.
